// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// Four display digits with sign and >9999 overflow flag.
module bin_to_bcd #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] value,
  output logic [3:0]   d3,
  output logic [3:0]   d2,
  output logic [3:0]   d1,
  output logic [3:0]   d0,
  output logic         neg,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t state;
  state_t nxt;

  logic [19:0]    bcd;
  logic [19:0]    bcd_adj;
  logic [W-1:0]   mag;
  logic [W-1:0]   neg_val;
  logic [19+W:0]  sh;
  logic [3:0]     cnt;
  logic           sign;
  logic           zero;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_SHIFT;
      S_SHIFT: if (cnt == 4'(W - 1)) nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // add-3 correction on each digit before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign sh      = {bcd_adj, mag} << 1;
  assign neg_val = ~value + {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd  <= '0;
      mag  <= '0;
      cnt  <= '0;
      sign <= 1'b0;
      zero <= 1'b0;
      d3   <= '0;
      d2   <= '0;
      d1   <= '0;
      d0   <= '0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (signed_mode && value[W-1]) mag <= neg_val;
            else                           mag <= value;
            sign <= signed_mode & value[W-1];
            zero <= (value == '0);
            bcd  <= '0;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          {bcd, mag} <= sh;
          cnt        <= cnt + 4'd1;
        end
        S_FIN: begin
          // a nonzero fifth digit means the value exceeds 9999
          if (bcd[19:16] != 4'd0) begin
            d3  <= 4'd9;
            d2  <= 4'd9;
            d1  <= 4'd9;
            d0  <= 4'd9;
            ovf <= 1'b1;
          end else begin
            d3  <= bcd[15:12];
            d2  <= bcd[11:8];
            d1  <= bcd[7:4];
            d0  <= bcd[3:0];
            ovf <= 1'b0;
          end
          neg  <= sign & ~zero;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: arithmetic reference model,
// directed corner cases plus random operands.
module tb_bin_to_bcd;

  localparam int W = 14;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       neg;
    logic       ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] value = '0;
  logic [3:0]   d3, d2, d1, d0;
  logic         neg, ovf, busy, done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  exp_t sb[$];

  bin_to_bcd #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_mode(signed_mode),
    .value(value),
    .d3(d3),
    .d2(d2),
    .d1(d1),
    .d0(d0),
    .neg(neg),
    .ovf(ovf),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] v, input logic sm);
    exp_t e;
    int m;
    m = int'(v);
    if (sm && v[W-1]) m = (1 << W) - m;
    e.neg = sm && v[W-1] && (m != 0);
    if (m > 9999) begin
      e.ovf = 1'b1;
      m = 9999;
    end else begin
      e.ovf = 1'b0;
    end
    e.d3 = 4'(m / 1000);
    e.d2 = 4'((m / 100) % 10);
    e.d1 = 4'((m / 10) % 10);
    e.d0 = 4'(m % 10);
    return e;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      got = '{d3, d2, d1, d0, neg, ovf};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got %h want no done", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL result: got %h want %h", got, e);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] v, input logic sm);
    @(negedge clk);
    start = 1'b1;
    value = v;
    signed_mode = sm;
    @(posedge clk);
    sb.push_back(model(v, sm));
  endtask

  // called right after the accepting edge; measures latency and busy
  task automatic wait_done(input bit hold, input logic [W-1:0] nv);
    int edges;
    int busy_n;
    @(negedge clk);
    if (hold) value = nv;
    else      start = 1'b0;
    busy_n = busy ? 1 : 0;
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_n++;
    end
    check("latency", edges, W + 1);
    check("busy_cycles", busy_n, W + 1);
    check("busy_at_done", int'(busy), 0);
  endtask

  task automatic convert(input logic [W-1:0] v, input logic sm);
    issue(v, sm);
    wait_done(1'b0, '0);
  endtask

  initial begin
    int dc0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_digits", int'({d3, d2, d1, d0}), 0);
    check("reset_flags", int'({neg, ovf, busy, done}), 0);

    convert(14'd0, 1'b0);
    convert(14'd9999, 1'b0);
    convert(14'd1234, 1'b0);
    convert(14'd12345, 1'b0);
    convert(14'h3FFF, 1'b1);
    convert(14'h2000, 1'b1);
    convert(14'h3FFF, 1'b0);

    // starts during SHIFT (edges 3 and 14) must be dropped
    issue(14'd4567, 1'b0);
    dc0 = done_cnt;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
      start = (k == 2 || k == 13);
      value = 14'd1;
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_starts_done_count", done_cnt - dc0, 1);
    check("ignored_starts_idle", int'(busy), 0);

    // start held high: the in-flight capture ignores value changes
    issue(14'd100, 1'b0);
    wait_done(1'b1, 14'd777);
    @(posedge clk);
    sb.push_back(model(14'd777, 1'b0));
    wait_done(1'b0, '0);

    // reset in the middle of SHIFT aborts without a done pulse
    issue(14'd4321, 1'b0);
    dc0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 7) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("abort_digits", int'({d3, d2, d1, d0}), 0);
    check("abort_flags", int'({neg, ovf, busy, done}), 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    convert(14'd42, 1'b0);

    for (int i = 0; i < 30; i++)
      convert(W'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
